// File: rtl/pingpong_pkg.sv
// rtl/pingpong_pkg.sv - shared defaults and FSM encoding for the ping-pong buffer controller
//
// Holds the default geometry (BRAM word width, nibble width, nibbles per
// word, last BRAM address) and the controller state encoding.

package pingpong_pkg;

    localparam int PP_WORD_W    = 256;
    localparam int PP_NIB_W     = 4;
    localparam int PP_NIBS      = PP_WORD_W / PP_NIB_W;
    localparam int PP_LAST_ADDR = 23;
    localparam int PP_ADDR_W    = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFETCH = 3'd1,
        LOAD     = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4
    } pp_state_t;

endpackage

// File: rtl/nibble_shifter.sv
// rtl/nibble_shifter.sv - loadable word register that rotates right one nibble per cycle
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture din (takes priority over rotate)
//   rotate     : rotate the register right by NIB_W
//   din        : word to load
//   nib        : lowest nibble of the register

module nibble_shifter
    import pingpong_pkg::*;
#(
    parameter int WORD_W = PP_WORD_W,
    parameter int NIB_W  = PP_NIB_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              rotate,
    input  logic [WORD_W-1:0] din,
    output logic [NIB_W-1:0]  nib
);

    logic [WORD_W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (rotate) begin
            sr <= {sr[NIB_W-1:0], sr[WORD_W-1:NIB_W]};
        end
    end

    assign nib = sr[NIB_W-1:0];

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// rtl/pingpong_buf_ctrl.sv - streams BRAM words as nibbles into two alternating FIFO banks
//
// Optional feature macro: PINGPONG_OVF_CHK_EN (adds full/empty inputs and a
// sticky err output flagging writes to a full bank or reads from an empty one).
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, stop         : one-cycle pulses to begin / gracefully end streaming
//   bram_addr           : source BRAM word address (read data one cycle later)
//   bram_dout           : source BRAM read data
//   din_buf             : nibble written to the filling bank
//   wr_en_0, wr_en_1    : per-bank write enables
//   rd_en_0, rd_en_1    : per-bank read enables
//   drain_sel           : bank currently being drained
//   busy                : controller not idle
//   swap                : one-cycle pulse on each bank exchange
//   full_0/1, empty_0/1 : bank status (PINGPONG_OVF_CHK_EN only)
//   err                 : sticky overflow/underflow flag (PINGPONG_OVF_CHK_EN only)

module pingpong_buf_ctrl
    import pingpong_pkg::*;
#(
    parameter int WORD_W    = PP_WORD_W,
    parameter int NIB_W     = PP_NIB_W,
    parameter int LAST_ADDR = PP_LAST_ADDR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    output logic [PP_ADDR_W-1:0] bram_addr,
    input  logic [WORD_W-1:0]    bram_dout,
    output logic [NIB_W-1:0]     din_buf,
    output logic                 wr_en_0,
    output logic                 wr_en_1,
    output logic                 rd_en_0,
    output logic                 rd_en_1,
    output logic                 drain_sel,
    output logic                 busy,
    output logic                 swap
`ifdef PINGPONG_OVF_CHK_EN
    ,
    input  logic                 full_0,
    input  logic                 full_1,
    input  logic                 empty_0,
    input  logic                 empty_1,
    output logic                 err
`endif
);

    localparam int NIBS  = WORD_W / NIB_W;
    localparam int CNT_W = $clog2(NIBS);
    localparam logic [CNT_W-1:0]     NIB_LAST  = CNT_W'(NIBS - 1);
    // Address advances two nibbles early: one cycle for the address to
    // register, one for the BRAM read, so the word is on bram_dout in the
    // last nibble cycle and is captured with no bubble.
    localparam logic [CNT_W-1:0]     NIB_FETCH = CNT_W'(NIBS - 3);
    localparam logic [PP_ADDR_W-1:0] ADDR_LAST = PP_ADDR_W'(LAST_ADDR);

    pp_state_t        state_q, state_d;
    logic [CNT_W-1:0] nib_cnt;
    logic             primed;
    logic             stop_lat;
    logic             drain_q;
    logic             word_end;
    logic             stop_req;
    logic             sh_load;
    logic             sh_rotate;
    logic [NIB_W-1:0] sh_nib;

    assign word_end  = (nib_cnt == NIB_LAST);
    assign stop_req  = stop_lat | stop;
    assign drain_sel = drain_q;

    nibble_shifter #(
        .WORD_W (WORD_W),
        .NIB_W  (NIB_W)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (sh_load),
        .rotate (sh_rotate),
        .din    (bram_dout),
        .nib    (sh_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fill bank is always !drain_sel; the drain bank is read only once it
    // has been filled at least once (primed) or while draining.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        wr_en_0   = 1'b0;
        wr_en_1   = 1'b0;
        rd_en_0   = 1'b0;
        rd_en_1   = 1'b0;
        swap      = 1'b0;
        din_buf   = '0;
        sh_load   = 1'b0;
        sh_rotate = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start && !stop) begin
                    state_d = PREFETCH;
                end
            end
            PREFETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                sh_load = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                wr_en_0   = drain_q;
                wr_en_1   = !drain_q;
                rd_en_0   = primed && !drain_q;
                rd_en_1   = primed && drain_q;
                din_buf   = sh_nib;
                sh_rotate = 1'b1;
                if (word_end) begin
                    swap = 1'b1;
                    if (stop_req) begin
                        state_d = DRAIN;
                    end else begin
                        sh_load = 1'b1;
                    end
                end
            end
            DRAIN: begin
                rd_en_0 = !drain_q;
                rd_en_1 = drain_q;
                if (word_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_cnt   <= '0;
            bram_addr <= '0;
            primed    <= 1'b0;
            stop_lat  <= 1'b0;
            drain_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    nib_cnt   <= '0;
                    bram_addr <= '0;
                    primed    <= 1'b0;
                    stop_lat  <= 1'b0;
                    // Point drain at bank 1 so the first word fills bank 0.
                    drain_q   <= start && !stop;
                end
                PREFETCH: begin
                    stop_lat <= stop_req;
                end
                LOAD: begin
                    nib_cnt  <= '0;
                    stop_lat <= stop_req;
                end
                STREAM: begin
                    nib_cnt  <= word_end ? '0 : nib_cnt + 1'b1;
                    stop_lat <= word_end ? 1'b0 : stop_req;
                    if (nib_cnt == NIB_FETCH && !stop_req) begin
                        bram_addr <= (bram_addr == ADDR_LAST) ? '0 : bram_addr + 1'b1;
                    end
                    if (word_end) begin
                        drain_q <= !drain_q;
                        primed  <= 1'b1;
                    end
                end
                DRAIN: begin
                    nib_cnt   <= word_end ? '0 : nib_cnt + 1'b1;
                    bram_addr <= '0;
                    stop_lat  <= 1'b0;
                    if (word_end) begin
                        drain_q <= 1'b0;
                    end
                end
                default: begin
                    nib_cnt <= '0;
                end
            endcase
        end
    end

`ifdef PINGPONG_OVF_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((wr_en_0 && full_0) || (wr_en_1 && full_1) ||
                     (rd_en_0 && empty_0) || (rd_en_1 && empty_1)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/pingpong_buf_ctrl.md
PINGPONG_BUF_CTRL -- requirements
Module: pingpong_buf_ctrl

Interface
REQ-001 Parameter WORD_W, default 256: width of one BRAM word.
REQ-002 Parameter NIB_W, default 4: width of one buffer entry (nibble).
REQ-003 Parameter LAST_ADDR, default 23: highest BRAM word address used; the address wraps to 0 after it.
REQ-004 Port clk, in, 1: sole clock; all state changes on its rising edge.
REQ-005 Port rst_n, in, 1: asynchronous, active-low reset.
REQ-006 Port start, in, 1: one-cycle pulse that begins streaming.
REQ-007 Port stop, in, 1: one-cycle pulse that requests a graceful end.
REQ-008 Port bram_addr, out, 5: word address to the source BRAM.
REQ-009 Port bram_dout, in, WORD_W: BRAM read data, valid 1 cycle after the address.
REQ-010 Port din_buf, out, NIB_W: nibble written to the filling bank.
REQ-011 Ports wr_en_0 / wr_en_1, out, 1 each: write enable for FIFO bank 0 / bank 1.
REQ-012 Ports rd_en_0 / rd_en_1, out, 1 each: read enable for FIFO bank 0 / bank 1.
REQ-013 Port drain_sel, out, 1: bank currently being drained; its value equals the sr_in mux select.
REQ-014 Port busy, out, 1: high in any state other than IDLE.
REQ-015 Port swap, out, 1: one-cycle pulse on each bank exchange.

Function
REQ-016 NIBS = WORD_W/NIB_W (64 by default); nib_cnt SHALL be a 6-bit counter that wraps modulo NIBS.
REQ-017 FSM states SHALL be IDLE, PREFETCH, LOAD, STREAM, DRAIN.
REQ-018 IDLE -> PREFETCH on start; bram_addr SHALL be 0 in IDLE.
REQ-019 PREFETCH SHALL last 1 cycle, then go to LOAD; LOAD SHALL capture bram_dout into the shift register, set nib_cnt=0, then go to STREAM.
REQ-020 STREAM SHALL, each cycle, drive din_buf = shift_reg[NIB_W-1:0], assert wr_en of the fill bank (!drain_sel), and rotate the shift register right by NIB_W.
REQ-021 During STREAM, the rd_en of the drain bank SHALL be asserted only when the primed flag is set; primed is set by the first swap.
REQ-022 At nib_cnt == NIBS-1: drain_sel toggles, swap pulses, and the next word loads on the following cycle with no bubble.
REQ-023 bram_addr SHALL advance at nib_cnt == NIBS-3, so the next word is ready at the load cycle.
REQ-024 bram_addr SHALL wrap LAST_ADDR -> 0.
REQ-025 Exactly one wr_en and at most one rd_en SHALL be high per cycle; a bank SHALL never be written and read in the same cycle.
REQ-026 stop during STREAM SHALL be latched; the current word completes, then the FSM enters DRAIN: NIBS cycles of rd_en on the just-filled bank with no wr_en, then IDLE.
REQ-027 start while busy SHALL be ignored; start and stop together in IDLE: stop wins, stay IDLE.
REQ-028 stop in DRAIN or IDLE SHALL be ignored.

Reset
REQ-029 On rst_n low, all enables, swap, and busy SHALL be 0; bram_addr, nib_cnt, din_buf, and drain_sel SHALL be 0; primed and the stop latch SHALL be cleared; state SHALL be IDLE.
REQ-030 Reset mid-STREAM SHALL abort immediately with no further enable pulses; start is required to resume from address 0.

Configuration
REQ-031 With PINGPONG_OVF_CHK_EN defined, inputs full_0, full_1, empty_0, empty_1 and output err (sticky) SHALL exist.
REQ-032 Under PINGPONG_OVF_CHK_EN, err SHALL set when wr_en is issued to a full bank or rd_en to an empty bank; err clears only on reset.
REQ-033 Without PINGPONG_OVF_CHK_EN, these ports and this logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-034 Shared package pingpong_pkg SHALL hold the WORD_W/NIB_W/NIBS/LAST_ADDR defaults and the FSM state encoding.
REQ-035 Sub-module nibble_shifter (load/rotate WORD_W register, NIB_W output) SHALL be instantiated once.

Verification
REQ-036 Reset, then start with word0 = 0x...3210 (nibble i = i mod 16) -> din_buf = 0,1,2,... on consecutive cycles; wr_en_0 is high for 64 cycles; rd_en is low throughout (not primed).
REQ-037 Run 3 words -> swap is pulsed at cycles 64 and 128 after the first LOAD; during word 1, wr_en_1 = rd_en_0 = 1; during word 2, wr_en_0 = rd_en_1 = 1.
REQ-038 Run 25 words -> bram_addr sequence is 0..23, 0, with no bubble cycle between words.
REQ-039 stop at nib_cnt = 10 of word 2 -> word 2 completes, 64 DRAIN read cycles follow, then busy = 0; start pulses during DRAIN are ignored.
REQ-040 rst_n low at nib_cnt = 30 -> all outputs are 0 within the same cycle; after release, start restarts at address 0.
REQ-041 With PINGPONG_OVF_CHK_EN defined, force full_0 = 1 during a bank-0 fill -> err rises on the next edge and stays high until rst_n.
